// File: rtl/hdmi_frame_monitor.sv
// Per-frame geometry and checksum monitor for an HDMI pixel stream.
// Counts DE pixels per line and lines per frame, then reports at each vsync edge.
module hdmi_frame_monitor #(
  parameter int unsigned HORIZONTAL_RES = 64,
  parameter int unsigned VERTICAL_RES   = 64,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CHANNELS       = 3,
  parameter bit          VS_ACTIVE_LOW  = 1'b1,
  parameter int unsigned CNT_W          = 12
) (
  input  logic                  hdmi_clk,
  input  logic                  hdmi_rst_n,
  input  logic                  hdmi_vs,
  input  logic                  hdmi_de,
  input  logic [DATA_WIDTH-1:0] hdmi_data,
  output logic                  frame_done,
  output logic                  frame_ok,
  output logic [CNT_W-1:0]      frame_lines,
  output logic [CNT_W-1:0]      line_err_cnt,
  output logic [15:0]           frame_checksum,
  output logic [7:0]            frame_count,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StVsync, StActive} state_e;

  state_e           state_q, state_d;
  logic             vs_prev_q, vs_prev_d;
  logic             de_prev_q, de_prev_d;
  logic [CNT_W-1:0] pix_q, pix_d;
  logic [CNT_W-1:0] line_q, line_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [15:0]      sum_q, sum_d;
  logic             done_q, done_d;
  logic             ok_q, ok_d;
  logic [CNT_W-1:0] flines_q, flines_d;
  logic [CNT_W-1:0] ferr_q, ferr_d;
  logic [15:0]      fsum_q, fsum_d;
  logic [7:0]       fcnt_q, fcnt_d;
  logic             busy_q, busy_d;

  logic        vs_i;
  logic        frame_edge;
  logic        line_end;
  logic [15:0] pix_bytes;
  logic        unused_data;

  // Upper data bits beyond the colour channels are intentionally ignored.
  assign unused_data = ^hdmi_data;

  always_comb begin
    vs_i       = VS_ACTIVE_LOW ? ~hdmi_vs : hdmi_vs;
    frame_edge = vs_i & ~vs_prev_q;
    // A DE fall closes a line; so does a frame edge arriving mid-line.
    line_end   = (de_prev_q & ~hdmi_de) | (frame_edge & hdmi_de);
    pix_bytes  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      pix_bytes = pix_bytes + 16'(hdmi_data[8*i +: 8]);
    end
  end

  always_comb begin
    state_d   = state_q;
    vs_prev_d = vs_i;
    de_prev_d = (state_q == StActive) & hdmi_de;
    pix_d     = pix_q;
    line_d    = line_q;
    err_d     = err_q;
    sum_d     = sum_q;
    done_d    = 1'b0;
    ok_d      = ok_q;
    flines_d  = flines_q;
    ferr_d    = ferr_q;
    fsum_d    = fsum_q;
    fcnt_d    = fcnt_q;

    unique case (state_q)
      StIdle: begin
        if (frame_edge) state_d = StVsync;
      end
      StVsync: begin
        if (!vs_i) begin
          state_d = StActive;
          pix_d   = '0;
          line_d  = '0;
          err_d   = '0;
          sum_d   = '0;
        end
      end
      StActive: begin
        if (hdmi_de && !frame_edge) begin
          if (pix_q != '1) pix_d = pix_q + 1'b1;
          sum_d = sum_q + pix_bytes;
        end
        if (line_end) begin
          if (line_q != '1) line_d = line_q + 1'b1;
          if (pix_q != CNT_W'(HORIZONTAL_RES) && err_q != '1) err_d = err_q + 1'b1;
          pix_d = '0;
        end
        if (frame_edge) begin
          state_d  = StVsync;
          done_d   = 1'b1;
          flines_d = line_d;
          ferr_d   = err_d;
          fsum_d   = sum_q;
          ok_d     = (line_d == CNT_W'(VERTICAL_RES)) && (err_d == '0);
          fcnt_d   = fcnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StActive);
  end

  always_ff @(posedge hdmi_clk or negedge hdmi_rst_n) begin
    if (!hdmi_rst_n) begin
      state_q   <= StIdle;
      vs_prev_q <= 1'b1;
      de_prev_q <= 1'b0;
      pix_q     <= '0;
      line_q    <= '0;
      err_q     <= '0;
      sum_q     <= '0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      flines_q  <= '0;
      ferr_q    <= '0;
      fsum_q    <= '0;
      fcnt_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vs_prev_q <= vs_prev_d;
      de_prev_q <= de_prev_d;
      pix_q     <= pix_d;
      line_q    <= line_d;
      err_q     <= err_d;
      sum_q     <= sum_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
      flines_q  <= flines_d;
      ferr_q    <= ferr_d;
      fsum_q    <= fsum_d;
      fcnt_q    <= fcnt_d;
      busy_q    <= busy_d;
    end
  end

  assign frame_done     = done_q;
  assign frame_ok       = ok_q;
  assign frame_lines    = flines_q;
  assign line_err_cnt   = ferr_q;
  assign frame_checksum = fsum_q;
  assign frame_count    = fcnt_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_hdmi_frame_monitor.sv
// Self-checking bench for hdmi_frame_monitor: directed frame table, random frames
// against a frame-level model, and reset / wrap corner sequences.
module tb_hdmi_frame_monitor;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int CW = 12;

  logic        clk;
  logic        rst_n;
  logic        vs_act;
  logic        hdmi_vs;
  logic        hdmi_de;
  logic [31:0] hdmi_data;
  logic        frame_done;
  logic        frame_ok;
  logic [CW-1:0] frame_lines;
  logic [CW-1:0] line_err_cnt;
  logic [15:0] frame_checksum;
  logic [7:0]  frame_count;
  logic        busy;

  assign hdmi_vs = ~vs_act;

  hdmi_frame_monitor #(
    .HORIZONTAL_RES(H),
    .VERTICAL_RES  (V)
  ) dut (
    .hdmi_clk      (clk),
    .hdmi_rst_n    (rst_n),
    .hdmi_vs       (hdmi_vs),
    .hdmi_de       (hdmi_de),
    .hdmi_data     (hdmi_data),
    .frame_done    (frame_done),
    .frame_ok      (frame_ok),
    .frame_lines   (frame_lines),
    .line_err_cnt  (line_err_cnt),
    .frame_checksum(frame_checksum),
    .frame_count   (frame_count),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]      nlines;
    logic [3:0][2:0] pix;
    logic [31:0]     data;
    logic            de_edge;
    logic [3:0]      e_lines;
    logic [3:0]      e_err;
    logic            e_ok;
    logic [15:0]     e_sum;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  // Frame-level model: lines seen, bad lines, byte sum, reports since reset.
  int m_lines, m_err, m_sum, m_fc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int byte_sum(input logic [31:0] d);
    int s = 0;
    for (int c = 0; c < 3; c++) s += int'((d >> (8 * c)) & 32'hFF);
    return s;
  endfunction

  task automatic send_line(input int n, input logic [31:0] d, input bit rnd, input bit keep_de);
    for (int i = 0; i < n; i++) begin
      hdmi_de   = 1'b1;
      hdmi_data = rnd ? $urandom : d;
      m_sum    += byte_sum(hdmi_data);
      tick;
    end
    m_lines++;
    if (n != H) m_err++;
    if (!keep_de) begin
      hdmi_de = 1'b0;
      tick;
      tick;
    end
  endtask

  task automatic frame_edge(input bit de_hi, input bit rep, input int el, input int ee,
                            input bit eok, input int esum);
    hdmi_de = de_hi;
    vs_act  = 1'b1;
    tick;
    hdmi_de = 1'b0;
    if (rep) begin
      m_fc++;
      chk("done", frame_done, 1);
      chk("ok", frame_ok, eok);
      chk("lines", frame_lines, el);
      chk("errs", line_err_cnt, ee);
      chk("checksum", frame_checksum, esum & 16'hFFFF);
      chk("count", frame_count, m_fc % 256);
    end else begin
      chk("no_done", frame_done, 0);
    end
    m_lines = 0;
    m_err   = 0;
    m_sum   = 0;
    tick;
    chk("done_one_cycle", frame_done, 0);
    chk("busy_vsync", busy, 0);
    vs_act = 1'b0;
    tick;
    chk("busy_active", busy, 1);
  endtask

  task automatic model_edge(input bit de_hi);
    frame_edge(de_hi, 1'b1, m_lines, m_err, (m_lines == V) && (m_err == 0), m_sum);
  endtask

  task automatic do_reset;
    rst_n   = 1'b0;
    m_lines = 0;
    m_err   = 0;
    m_sum   = 0;
    m_fc    = 0;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  function automatic vec_t mk(input int nl, input int p0, input int p1, input int p2,
                              input logic [31:0] d, input bit dee, input int el, input int ee,
                              input bit eok, input logic [15:0] es);
    vec_t v;
    v.nlines  = 3'(nl);
    v.pix     = {3'd0, 3'(p2), 3'(p1), 3'(p0)};
    v.data    = d;
    v.de_edge = dee;
    v.e_lines = 4'(el);
    v.e_err   = 4'(ee);
    v.e_ok    = eok;
    v.e_sum   = es;
    return v;
  endfunction

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    vecs[0] = mk(2, 4, 4, 0, 32'h00010203, 0, 2, 0, 1, 16'h0030);
    vecs[1] = mk(2, 4, 3, 0, 32'h00010203, 0, 2, 1, 0, 16'h002A);
    vecs[2] = mk(3, 4, 4, 4, 32'h00010203, 0, 3, 0, 0, 16'h0048);
    vecs[3] = mk(2, 4, 4, 0, 32'h00FFFFFF, 0, 2, 0, 1, 16'h17E8);
    vecs[4] = mk(2, 4, 4, 0, 32'h00010203, 1, 2, 0, 1, 16'h0030);

    rst_n = 1'b0; vs_act = 1'b0; hdmi_de = 1'b0; hdmi_data = '0;
    m_lines = 0; m_err = 0; m_sum = 0; m_fc = 0;
    #12;
    chk("rst_done", frame_done, 0);
    chk("rst_count", frame_count, 0);
    chk("rst_busy", busy, 0);
    do_reset;
    frame_edge(0, 0, 0, 0, 0, 0);

    // Directed frame table
    for (int k = 0; k < 5; k++) begin
      for (int l = 0; l < int'(vecs[k].nlines); l++) begin
        send_line(int'(vecs[k].pix[l]), vecs[k].data, 0,
                  vecs[k].de_edge && (l == int'(vecs[k].nlines) - 1));
      end
      frame_edge(vecs[k].de_edge, 1, int'(vecs[k].e_lines), int'(vecs[k].e_err),
                 vecs[k].e_ok, int'(vecs[k].e_sum));
    end

    // Random frames against the model
    for (int f = 0; f < 25; f++) begin
      int nl = $urandom_range(0, 3);
      bit kd = (nl > 0) && ($urandom_range(0, 1) == 1);
      for (int l = 0; l < nl; l++) send_line($urandom_range(1, 6), '0, 1, kd && (l == nl - 1));
      model_edge(kd);
    end

    // Asynchronous reset mid-cycle with non-zero report outputs
    send_line(4, 32'h00010203, 0, 0);
    send_line(4, 32'h00010203, 0, 0);
    model_edge(0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_done", frame_done, 0);
    chk("async_ok", frame_ok, 0);
    chk("async_lines", frame_lines, 0);
    chk("async_errs", line_err_cnt, 0);
    chk("async_sum", frame_checksum, 0);
    chk("async_count", frame_count, 0);
    chk("async_busy", busy, 0);
    do_reset;

    // Reset in the middle of ACTIVE discards the frame
    frame_edge(0, 0, 0, 0, 0, 0);
    send_line(4, 32'h00010203, 0, 0);
    hdmi_de = 1'b1;
    tick;
    do_reset;
    hdmi_de = 1'b0;
    frame_edge(0, 0, 0, 0, 0, 0);
    send_line(4, 32'h00000001, 0, 0);
    send_line(4, 32'h00000001, 0, 0);
    frame_edge(0, 1, 2, 0, 1, 8);

    // vs already active at reset release: no edge until it has been low
    rst_n  = 1'b0;
    vs_act = 1'b1;
    m_lines = 0; m_err = 0; m_sum = 0; m_fc = 0;
    tick;
    rst_n = 1'b1;
    tick; tick; tick;
    chk("vs_high_busy", busy, 0);
    chk("vs_high_done", frame_done, 0);
    vs_act = 1'b0;
    tick;
    chk("vs_low_busy", busy, 0);
    frame_edge(0, 0, 0, 0, 0, 0);

    // frame_count wraps after 300 reports
    for (int f = 0; f < 300; f++) model_edge(0);
    chk("count_wrap", frame_count, 44);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
